// File: rtl/mult_div_ctrl_pkg.sv
// ============================================================================
// Module   : mult_div_pkg
// Brief    : Shared types and constants for the iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mult_div_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_ctrl_if.sv
// ============================================================================
// Module   : mult_div_ctrl_if
// Brief    : Request/result bundle between the control unit and mult_div_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_div_ctrl_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             hi_lo_write;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi_lo_write, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi_lo_write, hi, lo, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/mult_div_ctrl_shift_core.sv
// ============================================================================
// Module   : md_shift_core
// Brief    : Shared 2W accumulator; one shift-add or restoring step per enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_shift_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               op,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc
);

  // mult: acc = {partial product, remaining multiplier bits}
  // div : acc = {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_fits;

  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_fits  = (w_shift >= {1'b0, r_opnd});
    w_sub   = w_shift[WIDTH-1:0] - r_opnd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (load) begin
      r_opnd <= (op == OP_DIV) ? mag_b : mag_a;
      r_acc  <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? mag_a : mag_b)};
    end else if (step) begin
      if (op == OP_MULT) begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end else begin
        r_acc <= {(w_fits ? w_sub : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_fits};
      end
    end
  end

  assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/mult_div_ctrl.sv
// ============================================================================
// Module   : mult_div_ctrl
// Brief    : Sequencer for the signed iterative multiply/divide behind HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_step;
  logic               w_core_op;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_b_zero  = (bus.b == '0);
  assign w_step    = (r_state == ITER);
  assign w_mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;
  // The core sees the incoming op while loading, the latched op afterwards.
  assign w_core_op = (r_state == IDLE) ? bus.op : r_op;

  md_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .load  (w_accept),
    .step  (w_step),
    .op    (w_core_op),
    .mag_a (w_mag_a),
    .mag_b (w_mag_b),
    .acc   (w_acc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = ((bus.op == OP_DIV) && w_b_zero) ? DONE : ITER;
      ITER:    if (r_cnt == c_last) w_next = SIGN;
      SIGN:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state != IDLE);
    bus.done        = (r_state == DONE);
    bus.hi_lo_write = (r_state == DONE) && !r_div_zero;
  end

  // Remainder follows the dividend sign; quotient/product follow sign(a)^sign(b).
  assign w_prod = r_neg_q ? -w_acc : w_acc;
  assign w_quot = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= bus.op;
        r_neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        r_neg_r    <= bus.a[WIDTH-1];
        r_div_zero <= (bus.op == OP_DIV) && w_b_zero;
        r_cnt      <= '0;
      end else if (r_state == ITER) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == SIGN) begin
        if (r_op == OP_MULT) begin
          {r_hi, r_lo} <= w_prod;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
// ============================================================================
// Module   : tb_mult_div_ctrl
// Brief    : Directed and randomized checks of mult_div_ctrl against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_ctrl;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         n_chk   = 0;
  int         n_fail  = 0;
  bit         in_done = 1'b0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;
  logic         m_dz  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic (division truncates toward zero).
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, res, rem;
    sa = $signed(a);
    sb = $signed(b);
    if (op) begin
      if (b == '0) begin
        m_dz = 1'b1;
      end else begin
        res  = sa / sb;
        rem  = sa % sb;
        m_lo = res[W-1:0];
        m_hi = rem[W-1:0];
        m_dz = 1'b0;
      end
    end else begin
      res  = sa * sb;
      m_hi = res[2*W-1:W];
      m_lo = res[W-1:0];
      m_dz = 1'b0;
    end
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mid_at, input bit chk_after);
    int waits = 0;
    int cyc   = 0;
    int exp_wait;
    exp_wait  = in_done ? 2 : 1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    do begin
      @(negedge clock);
      waits++;
    end while (!bus.busy && waits < 4);
    check("accept_wait", 64'(waits), 64'(exp_wait));
    bus.start = 1'b0;
    model(op, a, b);
    while (!bus.done && cyc < 80) begin
      @(negedge clock);
      cyc++;
      if (cyc == mid_at) begin
        check("busy_mid", 64'(bus.busy), 64'(1));
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("latency", 64'(cyc), 64'(m_dz ? 0 : W + 1));
    check("done", 64'(bus.done), 64'(1));
    check("busy_done", 64'(bus.busy), 64'(1));
    check("hi", 64'(bus.hi), 64'(m_hi));
    check("lo", 64'(bus.lo), 64'(m_lo));
    check("hi_lo_write", 64'(bus.hi_lo_write), 64'(!m_dz));
    check("div_zero", 64'(bus.div_zero), 64'(m_dz));
    in_done = !chk_after;
    if (chk_after) begin
      @(negedge clock);
      check("done_pulse", 64'(bus.done), 64'(0));
      check("write_pulse", 64'(bus.hi_lo_write), 64'(0));
      check("busy_idle", 64'(bus.busy), 64'(0));
      check("hi_hold", 64'(bus.hi), 64'(m_hi));
      check("lo_hold", 64'(bus.lo), 64'(m_lo));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_write"}, 64'(bus.hi_lo_write), 64'(0));
    check({tag, "_dz"}, 64'(bus.div_zero), 64'(0));
    check({tag, "_hi"}, 64'(bus.hi), 64'(0));
    check({tag, "_lo"}, 64'(bus.lo), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op(1'b0, 32'd7, -32'sd3, -1, 1'b1);
    run_op(1'b1, -32'sd7, 32'd2, -1, 1'b1);
    run_op(1'b1, 32'd5, 32'd0, -1, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, 1'b1);
    run_op(1'b0, 32'd0, $urandom, -1, 1'b1);
    run_op(1'b1, $urandom, W'($urandom_range(1, 1000)), 10, 1'b1);
    run_op(1'b0, $urandom, $urandom, 10, 1'b1);

    // Asynchronous reset in the middle of an iteration.
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (15) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clock);
    reset   = 1'b1;
    m_hi    = '0;
    m_lo    = '0;
    m_dz    = 1'b0;
    in_done = 1'b0;
    @(negedge clock);
    run_op(1'b0, -32'sd12345, 32'd678, -1, 1'b1);

    for (int i = 0; i < 18; i++) begin
      logic         r_op_sel;
      logic [W-1:0] r_a, r_b;
      r_op_sel = 1'($urandom_range(0, 1));
      r_a      = pick();
      r_b      = pick();
      run_op(r_op_sel, r_a, r_b, -1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
